// File: rtl/lsu_stage_pkg.sv
// Shared types for the memory stage.
//   Uop    : exception code and register index shared by the pipeline stages.
//   LsuPkg : access size, packed memOp layout, FSM state encoding and a
//            size-to-bytes helper.
package Uop;
    typedef enum logic [1:0] {
        EX_NONE      = 2'd0,
        EX_DECODE    = 2'd1,
        EX_MEM_ALIGN = 2'd2,
        EX_MEM_MISS  = 2'd3
    } ex_t;

    typedef logic [4:0] reg_t;
endpackage

package LsuPkg;
    typedef enum logic [2:0] {
        MEM_OP_SZ_B = 3'd0,
        MEM_OP_SZ_H = 3'd1,
        MEM_OP_SZ_W = 3'd2,
        MEM_OP_SZ_D = 3'd3
    } mem_op_sz_t;

    // {en, isSt, signExtend, sz[2:0]}
    typedef struct packed {
        logic       en;
        logic       isSt;
        logic       signExtend;
        mem_op_sz_t sz;
    } lsu_mem_op_t;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_WAIT = 2'd2
    } lsu_state_t;

    // Only meaningful for B/H/W/D; larger codes are rejected as decode errors.
    function automatic int unsigned sz_bytes(input mem_op_sz_t sz);
        return 32'd1 << sz[1:0];
    endfunction
endpackage

// File: rtl/lsu_stage_lane.sv
// lsu_lane: combinational lane logic for one XLEN-wide data bus word.
//   i_off/i_sz/i_signExt : byte offset in the word, access size, sign-extend
//   i_rdata -> o_ldVal   : addressed lane extracted and extended to XLEN
//   i_stData -> o_wdata  : low size bytes replicated across every lane
//   o_be                 : byte enables covering exactly the addressed bytes
module lsu_lane
    import LsuPkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [$clog2(XLEN/8)-1:0] i_off,
    input  logic [2:0]                i_sz,
    input  logic                      i_signExt,
    input  logic [XLEN-1:0]           i_stData,
    input  logic [XLEN-1:0]           i_rdata,
    output logic [XLEN-1:0]           o_ldVal,
    output logic [XLEN-1:0]           o_wdata,
    output logic [XLEN/8-1:0]         o_be
);
    localparam int NB = XLEN / 8;

    logic [XLEN-1:0] w_sh;
    logic [XLEN-1:0] w_mask;
    logic            w_msb;
    int              w_nb;

    always_comb begin
        w_sh = i_rdata >> {i_off, 3'b000};
        w_nb = 1 << i_sz[1:0];
        case (mem_op_sz_t'(i_sz))
            MEM_OP_SZ_B: begin w_mask = XLEN'(8'hFF);         w_msb = w_sh[7];      end
            MEM_OP_SZ_H: begin w_mask = XLEN'(16'hFFFF);      w_msb = w_sh[15];     end
            MEM_OP_SZ_W: begin w_mask = XLEN'(32'hFFFF_FFFF); w_msb = w_sh[31];     end
            default:     begin w_mask = '1;                   w_msb = w_sh[XLEN-1]; end
        endcase
        o_ldVal = w_sh & w_mask;
        if (i_signExt && w_msb) o_ldVal = o_ldVal | ~w_mask;
        o_wdata = '0;
        o_be    = '0;
        for (int i = 0; i < NB; i++) begin
            // size is a power of two, so the source byte index wraps with a mask
            o_wdata[i*8 +: 8] = i_stData[(i & (w_nb - 1))*8 +: 8];
            o_be[i]           = (i >= int'(i_off)) && (i < int'(i_off) + w_nb);
        end
    end
endmodule

// File: rtl/lsu_stage.sv
// lsu_stage: memory stage between execute and writeback.
//   in*   : execute uop (valid/ready, ex, rd, effective address, store data, memOp)
//   out*  : result to writeback (valid/ready, ex, rd, value)
//   bus*  : single-outstanding data bus (req/gnt, then rvalid/rdata/err)
// Optional LSU_PERF_CNT_EN adds perfLoads, perfStores, perfStallCycles.
module lsu_stage
    import Uop::*;
    import LsuPkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic              inValid,
    output logic              inReady,
    input  logic [1:0]        inEx,
    input  logic [4:0]        inRd,
    input  logic [XLEN-1:0]   inAddr,
    input  logic [XLEN-1:0]   inStVal,
    input  logic [5:0]        inMemOp,
    output logic              outValid,
    input  logic              outReady,
    output logic [1:0]        outEx,
    output logic [4:0]        outRd,
    output logic [XLEN-1:0]   outVal,
    output logic              busReq,
    output logic              busWe,
    output logic [XLEN-1:0]   busAddr,
    output logic [XLEN-1:0]   busWdata,
    output logic [XLEN/8-1:0] busBe,
    input  logic              busGnt,
    input  logic              busRvalid,
    input  logic [XLEN-1:0]   busRdata,
    input  logic              busErr
`ifdef LSU_PERF_CNT_EN
    ,
    output logic [31:0]       perfLoads,
    output logic [31:0]       perfStores,
    output logic [31:0]       perfStallCycles
`endif
);
    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);
    localparam int CW   = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

    lsu_state_t      r_state, w_next;
    lsu_mem_op_t     w_op;
    logic            w_inReady, w_busReq, w_accept, w_pass, w_decErr, w_misalign, w_start, w_tmo;
    logic [OFFW-1:0] w_szMask;
    logic [CW-1:0]   r_cnt;

    logic            r_outValid;
    logic [1:0]      r_outEx;
    reg_t            r_outRd;
    logic [XLEN-1:0] r_outVal;
    logic            r_busWe;
    logic [XLEN-1:0] r_busAddr, r_busWdata;
    logic [NB-1:0]   r_busBe;

    reg_t            r_rd;
    logic            r_isSt, r_sign;
    logic [2:0]      r_sz;
    logic [OFFW-1:0] r_off;

    logic [OFFW-1:0] w_lOff;
    logic [2:0]      w_lSz;
    logic            w_lSign;
    logic [XLEN-1:0] w_ldVal, w_wdata;
    logic [NB-1:0]   w_be;

    assign w_op       = lsu_mem_op_t'(inMemOp);
    assign w_szMask   = OFFW'(sz_bytes(w_op.sz) - 1);
    assign w_pass     = (inEx != EX_NONE) || !w_op.en;
    assign w_decErr   = (w_op.sz > MEM_OP_SZ_D) || ((w_op.sz == MEM_OP_SZ_D) && (XLEN == 32));
    assign w_misalign = |(inAddr[OFFW-1:0] & w_szMask);
    assign w_accept   = inValid && w_inReady;
    assign w_start    = w_accept && !w_pass && !w_decErr && !w_misalign;
    // rvalid wins over the timeout on the last WAIT cycle
    assign w_tmo      = (r_state == LSU_WAIT) && !busRvalid && (r_cnt == TMO_LAST);

    // The lane decodes the incoming uop while idle (store data, byte enables)
    // and the captured access while waiting (load extraction).
    assign w_lOff  = (r_state == LSU_IDLE) ? inAddr[OFFW-1:0] : r_off;
    assign w_lSz   = (r_state == LSU_IDLE) ? w_op.sz          : r_sz;
    assign w_lSign = (r_state == LSU_IDLE) ? w_op.signExtend  : r_sign;

    lsu_lane #(.XLEN(XLEN)) u_lane (
        .i_off     (w_lOff),
        .i_sz      (w_lSz),
        .i_signExt (w_lSign),
        .i_stData  (inStVal),
        .i_rdata   (busRdata),
        .o_ldVal   (w_ldVal),
        .o_wdata   (w_wdata),
        .o_be      (w_be)
    );

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) r_state <= LSU_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            LSU_IDLE: if (w_start)             w_next = LSU_REQ;
            LSU_REQ:  if (busGnt)              w_next = LSU_WAIT;
            LSU_WAIT: if (busRvalid || w_tmo)  w_next = LSU_IDLE;
            default:                           w_next = LSU_IDLE;
        endcase
    end

    always_comb begin
        w_inReady = (r_state == LSU_IDLE) && (!r_outValid || outReady);
        w_busReq  = (r_state == LSU_REQ);
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_outValid <= 1'b0;
            r_outEx    <= EX_NONE;
            r_outRd    <= '0;
            r_outVal   <= '0;
            r_busWe    <= 1'b0;
            r_busAddr  <= '0;
            r_busWdata <= '0;
            r_busBe    <= '0;
            r_cnt      <= '0;
            r_rd       <= '0;
            r_isSt     <= 1'b0;
            r_sign     <= 1'b0;
            r_sz       <= '0;
            r_off      <= '0;
        end else begin
            if (r_outValid && outReady) r_outValid <= 1'b0;
            if (w_accept) begin
                if (w_pass || w_decErr || w_misalign) begin
                    r_outValid <= 1'b1;
                    r_outRd    <= inRd;
                    r_outEx    <= w_pass ? inEx : (w_decErr ? EX_DECODE : EX_MEM_ALIGN);
                    r_outVal   <= w_pass ? inAddr : '0;
                end else begin
                    r_busAddr  <= {inAddr[XLEN-1:OFFW], {OFFW{1'b0}}};
                    r_busWe    <= w_op.isSt;
                    r_busBe    <= w_be;
                    r_busWdata <= w_wdata;
                    r_rd       <= inRd;
                    r_isSt     <= w_op.isSt;
                    r_sign     <= w_op.signExtend;
                    r_sz       <= w_op.sz;
                    r_off      <= inAddr[OFFW-1:0];
                end
            end
            if (r_state == LSU_REQ && busGnt) r_cnt <= '0;
            if (r_state == LSU_WAIT) begin
                if (busRvalid) begin
                    r_outValid <= 1'b1;
                    r_outRd    <= r_rd;
                    r_outEx    <= busErr ? EX_MEM_MISS : EX_NONE;
                    r_outVal   <= (busErr || r_isSt) ? '0 : w_ldVal;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_tmo) begin
                        r_outValid <= 1'b1;
                        r_outRd    <= r_rd;
                        r_outEx    <= EX_MEM_MISS;
                        r_outVal   <= '0;
                    end
                end
            end
        end
    end

    assign inReady  = w_inReady;
    assign outValid = r_outValid;
    assign outEx    = r_outEx;
    assign outRd    = r_outRd;
    assign outVal   = r_outVal;
    assign busReq   = w_busReq;
    assign busWe    = r_busWe;
    assign busAddr  = r_busAddr;
    assign busWdata = r_busWdata;
    assign busBe    = r_busBe;

`ifdef LSU_PERF_CNT_EN
    logic [31:0] r_perfLd, r_perfSt, r_perfStall;

    // Faulted accesses (decode/alignment) complete at accept; bus accesses
    // complete on response or timeout. Upstream exceptions are not accesses.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_perfLd    <= '0;
            r_perfSt    <= '0;
            r_perfStall <= '0;
        end else begin
            if (w_accept && !w_pass && (w_decErr || w_misalign)) begin
                if (w_op.isSt) r_perfSt <= r_perfSt + 32'd1;
                else           r_perfLd <= r_perfLd + 32'd1;
            end else if (r_state == LSU_WAIT && (busRvalid || w_tmo)) begin
                if (r_isSt) r_perfSt <= r_perfSt + 32'd1;
                else        r_perfLd <= r_perfLd + 32'd1;
            end
            if (r_state != LSU_IDLE) r_perfStall <= r_perfStall + 32'd1;
        end
    end

    assign perfLoads       = r_perfLd;
    assign perfStores      = r_perfSt;
    assign perfStallCycles = r_perfStall;
`endif
endmodule
